csr_port_arb: RTL and testbench
===============================

// Module: csr_port_arb
// PURPOSE
// - Arbitrates the single CSR register-file access port among three requesters: ex, clint and the JTAG debug module (dbg).
// - Sits between the requesters and the CSR register file. It drives the file's write enable, write address, read address and write data, and returns read data.
// - Fixed priority: clint > ex > dbg. A clint lock keeps trap entry/exit CSR sequences atomic. A per-requester starvation counter guarantees forward progress.
// PARAMETERS
// - STARVE_LIMIT  default 4  consecutive denied cycles before a pending ex/dbg request is promoted; 0 disables promotion.
// - CNT_W         default 3  width of each starvation counter; must hold STARVE_LIMIT.
// PORTS
// - clk            in   1   clock
// - rst            in   1   synchronous reset, active-high
// - <r>_req_i      in   1   request valid, r in {ex, clint, dbg}; held until <r>_gnt_o
// - <r>_we_i       in   1   1 = write, 0 = read
// - <r>_addr_i     in   12  CSR address
// - <r>_wdata_i    in   32  write data
// - <r>_gnt_o      out  1   request accepted this cycle (combinational)
// - <r>_rvalid_o   out  1   one-cycle pulse: access completed
// - <r>_rdata_o    out  32  read data, valid with <r>_rvalid_o
// - clint_lock_i   in   1   while 1, only clint may be granted
// - csr_we_o       out  1   to CSR file: write enable
// - csr_waddr_o    out  12  to CSR file: write address
// - csr_raddr_o    out  12  to CSR file: read address
// - csr_wdata_o    out  32  to CSR file: write data
// - csr_rdata_i    in   32  from CSR file: combinational read data for csr_raddr_o
// - arb_conflicts_o out 32  contention counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: every register and output is 0, including csr_we_o, all rvalid/rdata outputs, starvation counters and the command stage.
// - Cycle N (arbitration): at most one gnt asserted.
//   - clint_lock_i=1: gnt = clint_req_i; ex and dbg are denied.
//   - Otherwise: if a starvation counter == STARVE_LIMIT (>0) and that requester is pending, grant it; dbg wins a tie with ex.
//   - Otherwise: fixed priority clint > ex > dbg.
// - Cycle N+1 (issue): the granted command is registered and drives csr_*.
//   - Read: csr_raddr_o = addr, csr_we_o = 0.
//   - Write: csr_we_o = 1, csr_waddr_o = csr_raddr_o = addr, csr_wdata_o = wdata. The CSR file bypass returns the new value.
//   - Idle cycle: csr_we_o = 0, addresses hold their last value.
// - Cycle N+2 (response): csr_rdata_i was captured at the end of N+1. The originating <r>_rvalid_o pulses for one cycle with <r>_rdata_o.
//   - Writes also pulse rvalid, acting as the acknowledge.
//   - rdata_o holds until the next completion for that requester.
// - Throughput: one access per cycle, back-to-back, across any requester mix. Latency req -> rvalid is 2 cycles.
// - Starvation counters (ex, dbg):
//   - Increment when pending and not granted; saturate at STARVE_LIMIT.
//   - Clear on grant, or when req drops.
//   - Frozen (not incremented) while clint_lock_i=1.
//   - clint has no counter.
// - A requester may issue its next request in the cycle after gnt; it need not wait for rvalid.
// - clint_lock_i rising while an ex/dbg command is in the issue stage: that command completes; only new grants are blocked.
// - rst asserted mid-operation: the in-flight command is dropped, no rvalid is produced, and csr_we_o = 0 the next cycle.
// CONFIGURATION
// - CSR_ARB_STATS_EN defined: arb_conflicts_o is a 32-bit counter incremented each cycle with >=2 requests pending. It wraps at 2^32 and clears on rst.
// - CSR_ARB_STATS_EN undefined: arb_conflicts_o tied to 0 and no counter logic is built.
// TESTING
// - All idle, ex read 0x305 with mtvec=0x8000_0100 -> ex_gnt_o=1 at N; csr_raddr_o=0x305, csr_we_o=0 at N+1; ex_rvalid_o=1, ex_rdata_o=0x8000_0100 at N+2.
// - ex, clint, dbg request in the same cycle -> grant order clint, ex, dbg on 3 consecutive cycles; each rvalid follows its gnt by 2 cycles.
// - STARVE_LIMIT=4; ex requests continuously with new addresses, dbg pending -> dbg denied 4 cycles, granted on cycle 5, then ex resumes.
// - clint_lock_i=1 for 3 cycles: clint writes 0x341=PC, 0x342=0xB, 0x300=0x1880; ex pending throughout -> ex gnt only after lock drops; CSR writes appear in exactly that order.
// - rst pulsed in the cycle after an ex write gnt -> no ex_rvalid_o, csr_we_o=0; with CSR_ARB_STATS_EN, arb_conflicts_o=0.
// - CSR_ARB_STATS_EN defined, 10 cycles with ex and dbg both pending -> arb_conflicts_o=10; undefined -> remains 0.

Source files
------------

// File: rtl/csr_port_arb.sv
// rtl/csr_port_arb.sv - single-port CSR register-file arbiter for ex, clint and dbg requesters
//
// Fixed priority clint > ex > dbg, with a clint lock for atomic trap sequences
// and starvation promotion for ex/dbg. Pipeline: grant (N), issue to the CSR
// file (N+1), completion pulse with captured read data (N+2).
// Optional feature macro: CSR_ARB_STATS_EN (builds the contention counter).
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   <r>_req_i, <r>_we_i               request valid / write flag, r in {ex, clint, dbg}
//   <r>_addr_i, <r>_wdata_i           12-bit CSR address / 32-bit write data
//   <r>_gnt_o                         combinational accept
//   <r>_rvalid_o, <r>_rdata_o         completion pulse / read data (held)
//   clint_lock_i                      while high only clint may be granted
//   csr_we_o, csr_waddr_o             CSR file write enable / write address
//   csr_raddr_o, csr_wdata_o          CSR file read address / write data
//   csr_rdata_i                       CSR file combinational read data
//   arb_conflicts_o                   cycles with two or more requests pending

module csr_port_arb #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_req_i,
    input  logic        ex_we_i,
    input  logic [11:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    output logic        ex_gnt_o,
    output logic        ex_rvalid_o,
    output logic [31:0] ex_rdata_o,
    input  logic        clint_req_i,
    input  logic        clint_we_i,
    input  logic [11:0] clint_addr_i,
    input  logic [31:0] clint_wdata_i,
    output logic        clint_gnt_o,
    output logic        clint_rvalid_o,
    output logic [31:0] clint_rdata_o,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [11:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_gnt_o,
    output logic        dbg_rvalid_o,
    output logic [31:0] dbg_rdata_o,
    input  logic        clint_lock_i,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [11:0] csr_raddr_o,
    output logic [31:0] csr_wdata_o,
    input  logic [31:0] csr_rdata_i,
    output logic [31:0] arb_conflicts_o
);

    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(STARVE_LIMIT);
    localparam bit               PROMOTE_EN = (STARVE_LIMIT != 0);

    // One-hot requester vectors: [0]=ex, [1]=clint, [2]=dbg
    logic [2:0]       gnt;
    logic             ex_starved, dbg_starved;
    logic [CNT_W-1:0] ex_cnt_q, ex_cnt_d, dbg_cnt_q, dbg_cnt_d;

    logic             sel_we;
    logic [11:0]      sel_addr;
    logic [31:0]      sel_wdata;

    logic [2:0]       iss_src_q, iss_src_d;
    logic             iss_we_q, iss_we_d;
    logic [11:0]      raddr_q, raddr_d, waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;

    logic [2:0]       rvalid_q, rvalid_d;
    logic [31:0]      ex_rdata_q, ex_rdata_d;
    logic [31:0]      clint_rdata_q, clint_rdata_d;
    logic [31:0]      dbg_rdata_q, dbg_rdata_d;

    assign ex_starved  = PROMOTE_EN && ex_req_i  && (ex_cnt_q  == LIMIT);
    assign dbg_starved = PROMOTE_EN && dbg_req_i && (dbg_cnt_q == LIMIT);

    // Grants are withheld during reset so a requester never sees an accept
    // for a command the pipeline is about to drop.
    always_comb begin
        gnt = 3'b000;
        if (!rst) begin
            if (clint_lock_i)     gnt[1] = clint_req_i;
            else if (dbg_starved) gnt[2] = 1'b1;
            else if (ex_starved)  gnt[0] = 1'b1;
            else if (clint_req_i) gnt[1] = 1'b1;
            else if (ex_req_i)    gnt[0] = 1'b1;
            else if (dbg_req_i)   gnt[2] = 1'b1;
        end
    end

    assign ex_gnt_o    = gnt[0];
    assign clint_gnt_o = gnt[1];
    assign dbg_gnt_o   = gnt[2];

    // Counters hold (rather than clear) while locked so a requester keeps its
    // accumulated wait across a trap sequence.
    always_comb begin
        ex_cnt_d  = ex_cnt_q;
        dbg_cnt_d = dbg_cnt_q;
        if (!ex_req_i || gnt[0])
            ex_cnt_d = '0;
        else if (!clint_lock_i && ex_cnt_q != LIMIT)
            ex_cnt_d = ex_cnt_q + 1'b1;
        if (!dbg_req_i || gnt[2])
            dbg_cnt_d = '0;
        else if (!clint_lock_i && dbg_cnt_q != LIMIT)
            dbg_cnt_d = dbg_cnt_q + 1'b1;
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt[1]) begin
            sel_we    = clint_we_i;
            sel_addr  = clint_addr_i;
            sel_wdata = clint_wdata_i;
        end else if (gnt[0]) begin
            sel_we    = ex_we_i;
            sel_addr  = ex_addr_i;
            sel_wdata = ex_wdata_i;
        end else if (gnt[2]) begin
            sel_we    = dbg_we_i;
            sel_addr  = dbg_addr_i;
            sel_wdata = dbg_wdata_i;
        end
    end

    // Issue stage: addresses and write data only move when a command is
    // accepted, so the CSR file sees stable values across idle cycles.
    always_comb begin
        iss_src_d = gnt;
        iss_we_d  = (|gnt) && sel_we;
        raddr_d   = (|gnt) ? sel_addr : raddr_q;
        waddr_d   = iss_we_d ? sel_addr  : waddr_q;
        wdata_d   = iss_we_d ? sel_wdata : wdata_q;
    end

    // Response stage: read data (or the bypassed write value) is captured at
    // the end of the issue cycle and steered to the originating requester.
    always_comb begin
        rvalid_d      = iss_src_q;
        ex_rdata_d    = rvalid_d[0] ? csr_rdata_i : ex_rdata_q;
        clint_rdata_d = rvalid_d[1] ? csr_rdata_i : clint_rdata_q;
        dbg_rdata_d   = rvalid_d[2] ? csr_rdata_i : dbg_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_cnt_q      <= '0;
            dbg_cnt_q     <= '0;
            iss_src_q     <= '0;
            iss_we_q      <= 1'b0;
            raddr_q       <= '0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            rvalid_q      <= '0;
            ex_rdata_q    <= '0;
            clint_rdata_q <= '0;
            dbg_rdata_q   <= '0;
        end else begin
            ex_cnt_q      <= ex_cnt_d;
            dbg_cnt_q     <= dbg_cnt_d;
            iss_src_q     <= iss_src_d;
            iss_we_q      <= iss_we_d;
            raddr_q       <= raddr_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            rvalid_q      <= rvalid_d;
            ex_rdata_q    <= ex_rdata_d;
            clint_rdata_q <= clint_rdata_d;
            dbg_rdata_q   <= dbg_rdata_d;
        end
    end

    assign csr_we_o       = iss_we_q;
    assign csr_raddr_o    = raddr_q;
    assign csr_waddr_o    = waddr_q;
    assign csr_wdata_o    = wdata_q;
    assign ex_rvalid_o    = rvalid_q[0];
    assign clint_rvalid_o = rvalid_q[1];
    assign dbg_rvalid_o   = rvalid_q[2];
    assign ex_rdata_o     = ex_rdata_q;
    assign clint_rdata_o  = clint_rdata_q;
    assign dbg_rdata_o    = dbg_rdata_q;

`ifdef CSR_ARB_STATS_EN
    logic [31:0] conflicts_q, conflicts_d;

    always_comb begin
        conflicts_d = conflicts_q;
        if ((ex_req_i && clint_req_i) || (ex_req_i && dbg_req_i) || (clint_req_i && dbg_req_i))
            conflicts_d = conflicts_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) conflicts_q <= '0;
        else     conflicts_q <= conflicts_d;
    end

    assign arb_conflicts_o = conflicts_q;
`else
    assign arb_conflicts_o = 32'd0;
`endif

endmodule

// File: tb/tb_csr_port_arb.sv
// tb/tb_csr_port_arb.sv - scoreboard bench for csr_port_arb with randomized traffic and directed scenarios

module tb_csr_port_arb;

    localparam int LIM = 4;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rv_t;

    typedef struct {
        int   cyc;
        cmd_t c;
    } iss_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        clint_lock_i;
    logic [2:0]  req;
    cmd_t        cur [3];
    logic        g_ex, g_cl, g_db, v_ex, v_cl, v_db;
    logic [31:0] d_ex, d_cl, d_db;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o, csr_raddr_o;
    logic [31:0] csr_wdata_o, csr_rdata_i, arb_conflicts_o;
    logic [2:0]  gnt_v, rv_v;
    logic [31:0] rd_v [3];

    assign gnt_v = {g_db, g_cl, g_ex};
    assign rv_v  = {v_db, v_cl, v_ex};
    assign rd_v[0] = d_ex;
    assign rd_v[1] = d_cl;
    assign rd_v[2] = d_db;

    csr_port_arb #(.STARVE_LIMIT(LIM), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .ex_req_i(req[0]), .ex_we_i(cur[0].we), .ex_addr_i(cur[0].addr), .ex_wdata_i(cur[0].wdata),
        .ex_gnt_o(g_ex), .ex_rvalid_o(v_ex), .ex_rdata_o(d_ex),
        .clint_req_i(req[1]), .clint_we_i(cur[1].we), .clint_addr_i(cur[1].addr), .clint_wdata_i(cur[1].wdata),
        .clint_gnt_o(g_cl), .clint_rvalid_o(v_cl), .clint_rdata_o(d_cl),
        .dbg_req_i(req[2]), .dbg_we_i(cur[2].we), .dbg_addr_i(cur[2].addr), .dbg_wdata_i(cur[2].wdata),
        .dbg_gnt_o(g_db), .dbg_rvalid_o(v_db), .dbg_rdata_o(d_db),
        .clint_lock_i(clint_lock_i),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_raddr_o(csr_raddr_o),
        .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i),
        .arb_conflicts_o(arb_conflicts_o)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    cmd_t        cmdq [3][$];
    rv_t         exp_rv [3][$];
    iss_t        issq [$];
    logic [2:0]  gnt_seen = 3'b000;
    bit          log_en = 1'b0;
    int          glog [$];
    int          gcyc [$];
    logic [43:0] wlog [$];
    logic [31:0] mem [0:4095];
    logic [31:0] mmem [0:4095];

    function automatic logic [31:0] init_val(int i);
        return (i == 12'h305) ? 32'h8000_0100 : (32'hC000_0000 | i);
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // CSR register file: combinational read with write bypass
    always_comb csr_rdata_i = csr_we_o ? csr_wdata_o : mem[csr_raddr_o];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (csr_we_o) mem[csr_waddr_o] = csr_wdata_o;
        end
    end

    // Requester drivers: hold each command until granted, then load the next
    initial begin
        req = 3'b000;
        for (int r = 0; r < 3; r++) cur[r] = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int r = 0; r < 3; r++) begin
                if (req[r] && gnt_seen[r]) req[r] = 1'b0;
                if (!req[r] && cmdq[r].size() > 0) begin
                    cur[r] = cmdq[r].pop_front();
                    req[r] = 1'b1;
                end
            end
        end
    end

    // Reference model: arbitration rules, starvation wait counts, sequential
    // CSR semantics in grant order, contention count
    initial begin
        int          wait_cnt [3];
        logic [31:0] cexp;
        logic [2:0]  eg;
        cmd_t        c;
        rv_t         rv;
        iss_t        is;
        int          npend;
        cexp = 0;
        for (int r = 0; r < 3; r++) wait_cnt[r] = 0;
        for (int i = 0; i < 4096; i++) mmem[i] = init_val(i);
        forever begin
            @(negedge clk);
            check("conflicts", arb_conflicts_o, cexp);
            eg = 3'b000;
            if (!rst) begin
                if (clint_lock_i)                          eg[1] = req[1];
                else if (req[2] && LIM > 0 && wait_cnt[2] == LIM) eg[2] = 1'b1;
                else if (req[0] && LIM > 0 && wait_cnt[0] == LIM) eg[0] = 1'b1;
                else if (req[1])                           eg[1] = 1'b1;
                else if (req[0])                           eg[0] = 1'b1;
                else if (req[2])                           eg[2] = 1'b1;
            end
            check("gnt", {29'd0, gnt_v}, {29'd0, eg});
            if (rst) begin
                for (int r = 0; r < 3; r++) wait_cnt[r] = 0;
                cexp = 0;
            end else begin
                npend = int'(req[0]) + int'(req[1]) + int'(req[2]);
`ifdef CSR_ARB_STATS_EN
                if (npend >= 2) cexp = cexp + 1;
`endif
                for (int r = 0; r < 3; r += 2) begin
                    if (!req[r] || eg[r])                      wait_cnt[r] = 0;
                    else if (!clint_lock_i && wait_cnt[r] < LIM) wait_cnt[r]++;
                end
                for (int r = 0; r < 3; r++) begin
                    if (eg[r]) begin
                        c = cur[r];
                        rv.cyc  = cyc + 2;
                        rv.data = c.we ? c.wdata : mmem[c.addr];
                        if (c.we) mmem[c.addr] = c.wdata;
                        exp_rv[r].push_back(rv);
                        is.cyc = cyc + 1;
                        is.c   = c;
                        issq.push_back(is);
                    end
                end
            end
            gnt_seen = gnt_v;
            if (log_en) begin
                for (int r = 0; r < 3; r++) begin
                    if (gnt_v[r]) begin
                        glog.push_back(r);
                        gcyc.push_back(cyc);
                    end
                end
            end
        end
    end

    // Monitor: pops expectations and compares against DUT outputs
    initial begin
        iss_t        is;
        rv_t         rv;
        bit          exp_v;
        forever begin
            @(negedge clk);
            while (issq.size() > 0 && issq[0].cyc < cyc) void'(issq.pop_front());
            if (issq.size() > 0 && issq[0].cyc == cyc) begin
                is = issq.pop_front();
                check("csr_we", {31'd0, csr_we_o}, {31'd0, is.c.we});
                check("csr_raddr", {20'd0, csr_raddr_o}, {20'd0, is.c.addr});
                if (is.c.we) begin
                    check("csr_waddr", {20'd0, csr_waddr_o}, {20'd0, is.c.addr});
                    check("csr_wdata", csr_wdata_o, is.c.wdata);
                end
            end else begin
                check("csr_we_idle", {31'd0, csr_we_o}, 32'd0);
            end
            if (log_en && csr_we_o) wlog.push_back({csr_waddr_o, csr_wdata_o});
            for (int r = 0; r < 3; r++) begin
                while (exp_rv[r].size() > 0 && exp_rv[r][0].cyc < cyc) void'(exp_rv[r].pop_front());
                exp_v = (exp_rv[r].size() > 0 && exp_rv[r][0].cyc == cyc);
                check($sformatf("rvalid[%0d]", r), {31'd0, rv_v[r]}, {31'd0, exp_v});
                if (exp_v) begin
                    rv = exp_rv[r].pop_front();
                    if (rv_v[r]) check($sformatf("rdata[%0d]", r), rd_v[r], rv.data);
                end
            end
        end
    end

    function automatic bit busy();
        bit b;
        b = (req != 3'b000) || (issq.size() != 0);
        for (int r = 0; r < 3; r++) b = b || (cmdq[r].size() != 0) || (exp_rv[r].size() != 0);
        return b;
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (busy() && t < 400) begin
            tick(1);
            t++;
        end
        check("drain_done", {31'd0, busy()}, 32'd0);
        tick(1);
    endtask

    task automatic push(int r, logic we, logic [11:0] a, logic [31:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d;
        cmdq[r].push_back(c);
    endtask

    task automatic start_log();
        glog.delete(); gcyc.delete(); wlog.delete();
        log_en = 1'b1;
    endtask

    task automatic check_glog(string nm, int exp[$]);
        log_en = 1'b0;
        check({nm, "_len"}, glog.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            check($sformatf("%s_who%0d", nm, i), (i < glog.size()) ? glog[i] : -1, exp[i]);
            check($sformatf("%s_cyc%0d", nm, i), (i < gcyc.size()) ? gcyc[i] - gcyc[0] : -1, i);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_a [$];
        logic [43:0] exp_w [$];
        int lock_left;
        logic [11:0] ra;

        rst = 1'b1;
        clint_lock_i = 1'b0;
        tick(2);
        @(negedge clk);
        check("rst_we", {31'd0, csr_we_o}, 32'd0);
        check("rst_rvalid", {29'd0, rv_v}, 32'd0);
        check("rst_rdata_ex", d_ex, 32'd0);
        check("rst_raddr", {20'd0, csr_raddr_o}, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // ex read of mtvec on an idle port
        start_log();
        push(0, 1'b0, 12'h305, 32'd0);
        drain();
        exp_a = '{0};
        check_glog("mtvec", exp_a);
        check("mtvec_rdata", d_ex, 32'h8000_0100);

        // simultaneous requests resolve clint, ex, dbg on consecutive cycles
        start_log();
        push(0, 1'b0, 12'h340, 32'd0);
        push(1, 1'b0, 12'h341, 32'd0);
        push(2, 1'b0, 12'h342, 32'd0);
        drain();
        exp_a = '{1, 0, 2};
        check_glog("prio", exp_a);

        // continuous ex traffic; dbg promoted after four denied cycles
        start_log();
        for (int i = 0; i < 8; i++) push(0, 1'b0, 12'h100 + 12'(i), 32'd0);
        push(2, 1'b0, 12'h7B0, 32'd0);
        drain();
        exp_a = '{0, 0, 0, 0, 2, 0, 0, 0, 0};
        check_glog("starve", exp_a);

        // clint trap-entry writes under lock; ex waits until lock drops
        start_log();
        push(1, 1'b1, 12'h341, 32'h0000_1234);
        push(1, 1'b1, 12'h342, 32'h0000_000B);
        push(1, 1'b1, 12'h300, 32'h0000_1880);
        push(0, 1'b0, 12'h341, 32'd0);
        tick(1);
        clint_lock_i = 1'b1;
        tick(3);
        clint_lock_i = 1'b0;
        drain();
        exp_a = '{1, 1, 1, 0};
        check_glog("lock", exp_a);
        exp_w = '{{12'h341, 32'h0000_1234}, {12'h342, 32'h0000_000B}, {12'h300, 32'h0000_1880}};
        check("lock_wlen", wlog.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("lock_wr%0d", i), (i < wlog.size()) ? wlog[i][31:0] : 32'hFFFF_FFFF, exp_w[i][31:0]);
        for (int i = 0; i < 3; i++)
            check($sformatf("lock_wa%0d", i), (i < wlog.size()) ? {20'd0, wlog[i][43:32]} : 32'hFFFF_FFFF,
                  {20'd0, exp_w[i][43:32]});

        // randomized mixed traffic with short lock windows
        lock_left = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int r = 0; r < 3; r++) begin
                if (cmdq[r].size() < 2 && $urandom_range(0, 7) < ((r == 0) ? 6 : (r == 1) ? 2 : 4)) begin
                    ra = 12'h340 + 12'($urandom_range(0, 7));
                    push(r, 1'($urandom_range(0, 1)), ra, $urandom);
                end
            end
            if (lock_left > 0) begin
                lock_left--;
                if (lock_left == 0) clint_lock_i = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                clint_lock_i = 1'b1;
                lock_left = $urandom_range(1, 3);
            end
            tick(1);
        end
        clint_lock_i = 1'b0;
        drain();

        // reset in the cycle after an ex write grant drops the write's response
        push(0, 1'b1, 12'h7C0, 32'hDEAD_BEEF);
        tick(2);
        rst = 1'b1;
        for (int r = 0; r < 3; r++) exp_rv[r].delete();
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_we", {31'd0, csr_we_o}, 32'd0);
        check("rst_mid_rvalid", {31'd0, v_ex}, 32'd0);
        check("rst_mid_conflicts", arb_conflicts_o, 32'd0);
        tick(1);
        drain();

        // ten cycles with ex and dbg both pending
        for (int i = 0; i < 12; i++) begin
            push(0, 1'b0, 12'h200 + 12'(i), 32'd0);
            push(2, 1'b0, 12'h280 + 12'(i), 32'd0);
        end
        tick(1);
        tick(10);
`ifdef CSR_ARB_STATS_EN
        check("stats_10", arb_conflicts_o, 32'd10);
`else
        check("stats_off", arb_conflicts_o, 32'd0);
`endif
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
